// File: rtl/bit_debounce_edge_pkg.sv
// Shared constants for the debounced single-bit input path.
// Also provides the sizing helper for the debounce counter.
package bit_debounce_edge_pkg;

    localparam int   DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int   COUNT_W_DEFAULT         = 8;
    localparam logic STABLE_RST              = 1'b0;

    // Smallest width that can hold cycles-1; never below one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/bit_debounce_edge_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
// Latency 2 edges, free running, no backpressure.
module bit_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bit_debounce_edge.sv
// Synchronise, debounce and edge-detect one input bit; count stable transitions.
// Latency DEBOUNCE_CYCLES+2 edges from d_in to q_stable; no backpressure, en freezes the filter.
module bit_debounce_edge
    import bit_debounce_edge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int COUNT_W         = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               d_in,
    input  logic               en,
    input  logic               clr,
    output logic               q_stable,
    output logic               qb_stable,
    output logic               rise,
    output logic               fall,
    output logic [COUNT_W-1:0] trans_count
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               sync2;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               q_nxt;
    logic               rise_nxt;
    logic               fall_nxt;
    logic [COUNT_W-1:0] tc_nxt;

    bit_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d_in),
        .q   (sync2)
    );

    always_comb begin
        cnt_nxt  = '0;
        q_nxt    = q_stable;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        // Any cycle where the input agrees with the stable level discards the partial count.
        if (en && (sync2 != q_stable)) begin
            if (cnt == CNT_MAX) begin
                q_nxt    = sync2;
                rise_nxt = sync2;
                fall_nxt = ~sync2;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        tc_nxt = trans_count;
        if (clr) begin
            tc_nxt = '0;
        end else if (rise_nxt || fall_nxt) begin
            tc_nxt = trans_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            q_stable    <= STABLE_RST;
            qb_stable   <= ~STABLE_RST;
            rise        <= 1'b0;
            fall        <= 1'b0;
            trans_count <= '0;
        end else begin
            cnt         <= cnt_nxt;
            q_stable    <= q_nxt;
            qb_stable   <= ~q_nxt;
            rise        <= rise_nxt;
            fall        <= fall_nxt;
            trans_count <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_bit_debounce_edge.sv
// Directed bench for bit_debounce_edge at default parameters.
module tb_bit_debounce_edge;

    logic       clk;
    logic       rst;
    logic       d_in;
    logic       en;
    logic       clr;
    logic       q_stable;
    logic       qb_stable;
    logic       rise;
    logic       fall;
    logic [7:0] trans_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       d;
        logic       en;
        logic       clr;
        logic       q;
        logic       r;
        logic       f;
        logic [7:0] tc;
    } vec_t;

    vec_t vecs[$];

    bit_debounce_edge dut (
        .clk         (clk),
        .rst         (rst),
        .d_in        (d_in),
        .en          (en),
        .clr         (clr),
        .q_stable    (q_stable),
        .qb_stable   (qb_stable),
        .rise        (rise),
        .fall        (fall),
        .trans_count (trans_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic q, input logic r, input logic f,
                             input logic [7:0] tc);
        check({tag, "_q"},    32'(q_stable),    32'(q));
        check({tag, "_qb"},   32'(qb_stable),   32'(!q));
        check({tag, "_rise"}, 32'(rise),        32'(r));
        check({tag, "_fall"}, 32'(fall),        32'(f));
        check({tag, "_tc"},   32'(trans_count), 32'(tc));
    endtask

    function automatic void add(input logic d, input logic e, input logic c, input logic q,
                                input logic r, input logic f, input logic [7:0] tc, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{d, e, c, q, r, f, tc});
    endfunction

    // Drive a new level and wait (bounded) for the stable output to adopt it.
    task automatic settle(input logic target);
        int n;
        n    = 0;
        d_in = target;
        while (q_stable !== target && n < 12) begin
            tick();
            n++;
        end
        check("settle_q",    32'(q_stable), 32'(target));
        check("settle_rise", 32'(rise),     32'(target));
        check("settle_fall", 32'(fall),     32'(!target));
    endtask

    initial begin
        // d, en, clr -> q, rise, fall, trans_count after the edge
        add(1, 1, 0, 0, 0, 0, 0, 5);   // clean rise
        add(1, 1, 0, 1, 1, 0, 1, 1);
        add(1, 1, 0, 1, 0, 0, 1, 1);
        add(0, 1, 0, 1, 0, 0, 1, 5);   // clean fall
        add(0, 1, 0, 0, 0, 1, 2, 1);
        add(0, 1, 0, 0, 0, 0, 2, 1);
        add(1, 1, 0, 0, 0, 0, 2, 3);   // three-cycle glitch
        add(0, 1, 0, 0, 0, 0, 2, 5);
        add(1, 1, 0, 0, 0, 0, 2, 5);   // full latency still required afterwards
        add(1, 1, 0, 1, 1, 0, 3, 1);
        add(1, 1, 0, 1, 0, 0, 3, 1);
        add(0, 1, 0, 1, 0, 0, 3, 5);
        add(0, 1, 0, 0, 0, 1, 4, 1);
        add(0, 1, 0, 0, 0, 0, 4, 1);
        add(1, 0, 0, 0, 0, 0, 4, 20);  // enable low freezes the level
        add(1, 1, 0, 0, 0, 0, 4, 3);
        add(1, 1, 0, 1, 1, 0, 5, 1);
        add(1, 1, 0, 1, 0, 0, 5, 1);

        rst  = 1'b1;
        d_in = 1'b0;
        en   = 1'b1;
        clr  = 1'b0;
        #2;
        check_out("reset0", 0, 0, 0, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();

        foreach (vecs[i]) begin
            d_in = vecs[i].d;
            en   = vecs[i].en;
            clr  = vecs[i].clr;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].f, vecs[i].tc);
        end

        // Asynchronous reset from a non-reset state, observed before any edge.
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0, 8'd0);
        d_in = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();

        // Reset when the debounce count has reached 2.
        d_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_out("pre_rst", 0, 0, 0, 8'd0);
        #2 rst = 1'b1;
        #1;
        check_out("mid_rst", 0, 0, 0, 8'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("post_rst%0d", i), 0, 0, 0, 8'd0);
        end
        tick();
        check_out("post_rst_set", 1, 1, 0, 8'd1);

        // Counter wrap over 256 transitions.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_tc", 32'(trans_count), 32'd0);
        for (int i = 0; i < 256; i++) begin
            settle((i % 2) == 0 ? 1'b0 : 1'b1);
            if (i == 254) check("tc_255", 32'(trans_count), 32'd255);
        end
        check("tc_wrap", 32'(trans_count), 32'd0);

        // clr on the same edge as a rise wins over the increment.
        settle(1'b0);
        check("tc_before_clr", 32'(trans_count), 32'd1);
        d_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("clr_wait_q%0d", i), 32'(q_stable), 32'd0);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_out("clr_rise", 1, 1, 0, 8'd0);
        tick();
        check_out("clr_after", 1, 0, 0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
